// File: rtl/acc_mem_engine_if.sv
// Control and memory pins of the accumulate engine; master is the engine, slave is the control/memory side.
interface acc_mem_engine_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] dest;
  logic              ready;
  logic              done;
  logic              overflow;
  logic [ADDR_W-1:0] address;
  logic              read_enable;
  logic              write_enable;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (
    input  start, base, count, dest, data_out,
    output ready, done, overflow, address, read_enable, write_enable, data_in
  );

  modport slave (
    output start, base, count, dest, data_out,
    input  ready, done, overflow, address, read_enable, write_enable, data_in
  );
endinterface

// File: rtl/acc_mem_engine.sv
// Sums count words from base and writes the result to dest; done N+3 cycles after start (2 for count=0).
// start is only accepted while ready=1; optional ACC_SATURATE_EN clamps the written result on overflow.
module acc_mem_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  acc_mem_engine_if.master bus
);

  localparam int ACC_W = DATA_W + ADDR_W + 1;
  localparam logic [ACC_W-1:0] DATA_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_LAST, S_WRITE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              read_enable_q, read_enable_d;
  logic              write_enable_q, write_enable_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  logic              accept;
  logic              last_rd;
  logic [ADDR_W-1:0] rd_addr_next;
  logic [ADDR_W-1:0] wr_dest;
  logic [DATA_W-1:0] result;

  assign accept  = (state_q == S_IDLE) && bus.start;
  assign last_rd = (idx_q == (count_q - (ADDR_W+1)'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (bus.count == '0) ? S_WRITE : S_READ;
      S_READ:  if (last_rd) state_d = S_LAST;
      S_LAST:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data lags the strobe by a cycle, so the first READ cycle has nothing to add yet.
  always_comb begin
    base_d     = base_q;
    count_d    = count_q;
    dest_d     = dest_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    overflow_d = overflow_q;
    if (accept) begin
      base_d  = bus.base;
      count_d = bus.count;
      dest_d  = bus.dest;
      idx_d   = '0;
      acc_d   = '0;
    end else if (state_q == S_READ) begin
      idx_d = idx_q + (ADDR_W+1)'(1);
      if (idx_q != '0) acc_d = acc_q + ACC_W'(bus.data_out);
    end else if (state_q == S_LAST) begin
      acc_d = acc_q + ACC_W'(bus.data_out);
    end
    if (accept) overflow_d = 1'b0;
    else        overflow_d = overflow_q | (acc_d > DATA_MAX);
  end

  assign rd_addr_next = accept ? bus.base : (base_q + idx_q[ADDR_W-1:0] + ADDR_W'(1));
  assign wr_dest      = accept ? bus.dest : dest_q;

`ifdef ACC_SATURATE_EN
  assign result = overflow_d ? {DATA_W{1'b1}} : acc_d[DATA_W-1:0];
`else
  assign result = acc_d[DATA_W-1:0];
`endif

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    read_enable_d  = (state_d == S_READ);
    write_enable_d = (state_d == S_WRITE);
    address_d      = '0;
    data_in_d      = '0;
    if (state_d == S_READ) begin
      address_d = rd_addr_next;
    end else if (state_d == S_WRITE) begin
      address_d = wr_dest;
      data_in_d = result;
    end
    done_d  = (state_q == S_WRITE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q          <= '0;
      base_q         <= '0;
      count_q        <= '0;
      dest_q         <= '0;
      acc_q          <= '0;
      overflow_q     <= 1'b0;
      address_q      <= '0;
      read_enable_q  <= 1'b0;
      write_enable_q <= 1'b0;
      data_in_q      <= '0;
      done_q         <= 1'b0;
      ready_q        <= 1'b1;
    end else begin
      idx_q          <= idx_d;
      base_q         <= base_d;
      count_q        <= count_d;
      dest_q         <= dest_d;
      acc_q          <= acc_d;
      overflow_q     <= overflow_d;
      address_q      <= address_d;
      read_enable_q  <= read_enable_d;
      write_enable_q <= write_enable_d;
      data_in_q      <= data_in_d;
      done_q         <= done_d;
      ready_q        <= ready_d;
    end
  end

  assign bus.ready        = ready_q;
  assign bus.done         = done_q;
  assign bus.overflow     = overflow_q;
  assign bus.address      = address_q;
  assign bus.read_enable  = read_enable_q;
  assign bus.write_enable = write_enable_q;
  assign bus.data_in      = data_in_q;

endmodule

// File: doc/acc_mem_engine.md
# acc_mem_engine

Parametrised memory-accumulate engine: on a Start request it reads Count consecutive words from a synchronous single-port memory beginning at a base address, sums them, and writes the DATA_W-bit result back to a destination address. It is the configurable successor to the fixed 32-word / 16-bit accumulator-plus-FSM pair. It adds programmable base, count and destination, pipelined one-read-per-cycle operation, and a sticky overflow flag. It sits between the control logic and the data memory, driving the memory's address, write-data and enable pins.

## Interface
- DATA_W, 16, memory word width and result width
- ADDR_W, 5, memory address width (depth 2^ADDR_W)
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only while Ready=1
- Base  in  ADDR_W  first read address, latched on accepted Start
- Count  in  ADDR_W+1  number of words to sum, 0..2^ADDR_W, latched on Start
- Dest  in  ADDR_W  result write address, latched on Start
- Ready  out  1  engine idle, Start will be accepted
- Done  out  1  one-cycle pulse after result write
- Overflow  out  1  sticky: true sum of last operation exceeded 2^DATA_W-1
- Address  out  ADDR_W  memory address
- ReadEnable  out  1  memory read strobe
- WriteEnable  out  1  memory write strobe
- DataIN  out  DATA_W  memory write data (result)
- DataOut  in  DATA_W  memory read data, valid one cycle after ReadEnable

## Operation
- Unsigned arithmetic. Internal accumulator ACC_W = DATA_W+ADDR_W+1 bits; it never wraps internally.
- States: IDLE, READ, LAST, WRITE.
- IDLE: Ready=1, all strobes 0. Start=1 at an edge latches Base/Count/Dest, clears the accumulator and Overflow, then goes to READ if Count>0, else to WRITE.
- READ: ReadEnable=1, Address = Base+i for i = 0..Count-1, one per cycle. Address wraps modulo 2^ADDR_W. At the end of each READ cycle after the first, DataOut (from the previous read) is added. After Count cycles → LAST.
- LAST: strobes 0. The final DataOut is added at the closing edge → WRITE.
- WRITE: WriteEnable=1, Address=Dest, DataIN=result for exactly one cycle → IDLE with Done=1 for one cycle.
- Overflow is set when the accumulator exceeds 2^DATA_W-1. It holds until the next accepted Start.
- Start while Ready=0 is ignored. Base/Count/Dest changes during an operation have no effect.
- Dest inside the read range is legal; the write always follows the last read.
- ReadEnable and WriteEnable are never high in the same cycle.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; Ready=1, Done=0, Overflow=0, Address=0, ReadEnable=0, WriteEnable=0, DataIN=0, accumulator=0.
- Reset mid-operation aborts immediately and no write is issued.
- Start accepted at edge E0: READ occupies cycles 1..N, LAST is cycle N+1, WRITE is cycle N+2, Done=1 in cycle N+3 (with Ready=1).
- Count=0: WRITE in cycle 1 with DataIN=0, Done in cycle 2.
- Start may be high in the Done cycle and is accepted; back-to-back throughput is N+3 cycles per operation.
- All outputs are registered.

## Configuration
- ACC_SATURATE_EN defined: when Overflow=1, DataIN = all-ones (2^DATA_W-1). Otherwise DataIN = exact sum.
- ACC_SATURATE_EN undefined: DataIN = accumulator[DATA_W-1:0] (modulo wrap). Overflow is still reported.

## Test plan
- Reset values: assert Reset=0 mid-READ → all outputs at reset values next cycle, no WriteEnable ever seen. Release → Ready=1.
- Basic: mem[0..3]=1,2,3,4, Base=0, Count=4, Dest=10 → reads at 0,1,2,3 in cycles 1-4, write mem[10]=10 in cycle 6, Done in cycle 7, Overflow=0.
- Wrap and full depth: Base=30, Count=3 (ADDR_W=5) → Address 30,31,0. Count=32 with all words 1 → result 32.
- Count=0 → write 0 to Dest in cycle 1, Done in cycle 2.
- Overflow: DATA_W=16, two words 0xFFFF and 0x0002 → Overflow=1. DataIN=0xFFFF with ACC_SATURATE_EN, 0x0001 without.
- Handshake: Start pulsed while busy is ignored. Start held high in the Done cycle → second operation begins next cycle with freshly latched Base/Count/Dest and Overflow cleared.
